// File: rtl/vga_pkg.sv
// Shared definitions for the VGA overlay blocks: font geometry, ROM address
// width, the ASCII character type and the banner state encoding.
package vga_pkg;

    localparam int FONT_W = 8;
    localparam int FONT_H = 16;
    localparam int ROM_AW = 11;

    typedef logic [6:0] ascii_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REVEAL = 2'd1,
        HOLD   = 2'd2
    } banner_state_e;

    // Font ROM address layout: character code in the upper bits, glyph row below.
    function automatic logic [ROM_AW-1:0] glyph_addr(input ascii_t ch, input logic [3:0] row);
        return {ch, row};
    endfunction

endpackage

// File: rtl/text_msg_ram.sv
// Message buffer: DEPTH ASCII characters, one write port and one registered
// read port. A read and a write of the same entry in one clock return the
// old character. Reads beyond DEPTH return 0 so the ROM address never goes X.
module text_msg_ram
    import vga_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  ascii_t     wr_char,
    input  logic [4:0] rd_addr,
    output ascii_t     rd_char
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ascii_t mem_r [DEPTH];
    ascii_t rd_char_r;

    // Write port; indices outside the buffer are dropped rather than aliased.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem_r[wr_addr[AW-1:0]] <= wr_char;
        end
    end

    // Registered read port; the output register is reset so the ROM address is clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_char_r <= 7'd0;
        end else if (32'(rd_addr) < DEPTH) begin
            rd_char_r <= mem_r[rd_addr[AW-1:0]];
        end else begin
            rd_char_r <= 7'd0;
        end
    end

    assign rd_char = rd_char_r;

endmodule

// File: rtl/draw_text_banner.sv
// Text-overlay renderer: rasterises a writable message at (X0,Y0), scaled by
// 2^SCALE_LOG2, through the shared 8x16 font ROM. Characters are revealed one
// per REVEAL_FRAMES frames, then the message holds (optionally blinking).
// Pixel pipeline: stage 0 geometry, stage 1 buffer read + ROM address,
// stage 2 ROM data combined with the delayed pixel flags (2-clock latency).
module draw_text_banner
    import vga_pkg::*;
#(
    parameter int MSG_LEN       = 16,
    parameter int SCALE_LOG2    = 2,
    parameter int X0            = 160,
    parameter int Y0            = 192,
    parameter int REVEAL_FRAMES = 4,
    parameter int BLINK_LOG2    = 5,
    parameter int BLINK_EN      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              frame_tick,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [6:0]        wr_char,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              text_on,
    output logic              busy
);

    localparam int BOX_W = (MSG_LEN * FONT_W) << SCALE_LOG2;
    localparam int BOX_H = FONT_H << SCALE_LOG2;
    localparam logic [5:0]          MSG_LEN_C = 6'(MSG_LEN);
    localparam logic [15:0]         RF_LAST   = 16'(REVEAL_FRAMES - 1);
    localparam logic [BLINK_LOG2:0] BLINK_ONE = (BLINK_LOG2+1)'(1);

    // Stage 0 geometry
    logic [9:0] dx_s;
    logic [9:0] dy_s;
    logic       in_box_s;
    logic [4:0] col_s;
    logic [3:0] grow_s;
    logic [2:0] bit_s;

    // Pipeline registers
    ascii_t     char_q_s;
    logic [3:0] grow_d1_r;
    logic       in_box_d1_r;
    logic       in_box_d2_r;
    logic [4:0] col_d1_r;
    logic [4:0] col_d2_r;
    logic [2:0] bit_d1_r;
    logic [2:0] bit_d2_r;

    // Sequencer state
    banner_state_e         state_r;
    logic [5:0]            reveal_cnt_r;
    logic [15:0]           frame_cnt_r;
    logic [BLINK_LOG2:0]   blink_cnt_r;
    logic                  busy_r;
    logic                  visible_s;

    // Box-relative offsets, box test and cell/row/bit selection for the current pixel.
    always_comb begin
        dx_s     = pix_x - 10'(X0);
        dy_s     = pix_y - 10'(Y0);
        in_box_s = (32'(pix_x) >= X0) && (32'(dx_s) < BOX_W) &&
                   (32'(pix_y) >= Y0) && (32'(dy_s) < BOX_H);
        col_s    = 5'(dx_s >> (3 + SCALE_LOG2));
        grow_s   = dy_s[3+SCALE_LOG2 -: 4];
        bit_s    = dx_s[2+SCALE_LOG2 -: 3];
    end

    text_msg_ram #(
        .DEPTH (MSG_LEN)
    ) u_msg_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_char (wr_char),
        .rd_addr (col_s),
        .rd_char (char_q_s)
    );

    // Delay the pixel flags alongside the buffer read and the ROM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grow_d1_r   <= 4'd0;
            in_box_d1_r <= 1'b0;
            in_box_d2_r <= 1'b0;
            col_d1_r    <= 5'd0;
            col_d2_r    <= 5'd0;
            bit_d1_r    <= 3'd0;
            bit_d2_r    <= 3'd0;
        end else begin
            grow_d1_r   <= grow_s;
            in_box_d1_r <= in_box_s;
            in_box_d2_r <= in_box_d1_r;
            col_d1_r    <= col_s;
            col_d2_r    <= col_d1_r;
            bit_d1_r    <= bit_s;
            bit_d2_r    <= bit_d1_r;
        end
    end

    assign rom_addr = glyph_addr(char_q_s, grow_d1_r);

    // Reveal/hold sequencer; advances on frame ticks, dropping enable always returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            reveal_cnt_r <= 6'd0;
            frame_cnt_r  <= 16'd0;
            blink_cnt_r  <= '0;
            busy_r       <= 1'b0;
        end else if (!enable) begin
            state_r      <= IDLE;
            reveal_cnt_r <= 6'd0;
            frame_cnt_r  <= 16'd0;
            blink_cnt_r  <= '0;
            busy_r       <= 1'b0;
        end else if (frame_tick) begin
            case (state_r)
                IDLE: begin
                    // The arming frame counts as the first reveal frame.
                    blink_cnt_r <= '0;
                    if (REVEAL_FRAMES == 0) begin
                        reveal_cnt_r <= MSG_LEN_C;
                        state_r      <= HOLD;
                        busy_r       <= 1'b0;
                    end else if (REVEAL_FRAMES == 1) begin
                        reveal_cnt_r <= 6'd1;
                        frame_cnt_r  <= 16'd0;
                        if (MSG_LEN == 1) begin
                            state_r <= HOLD;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= REVEAL;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        frame_cnt_r <= 16'd1;
                        state_r     <= REVEAL;
                        busy_r      <= 1'b1;
                    end
                end
                REVEAL: begin
                    if (frame_cnt_r == RF_LAST) begin
                        frame_cnt_r  <= 16'd0;
                        reveal_cnt_r <= reveal_cnt_r + 6'd1;
                        if (reveal_cnt_r + 6'd1 == MSG_LEN_C) begin
                            state_r <= HOLD;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        frame_cnt_r <= frame_cnt_r + 16'd1;
                    end
                end
                HOLD: begin
                    blink_cnt_r <= blink_cnt_r + BLINK_ONE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Blink only hides the text while holding; revealing text is always shown.
    always_comb begin
        visible_s = (BLINK_EN == 0) || (state_r != HOLD) || !blink_cnt_r[BLINK_LOG2];
    end

    // Final pixel decision, aligned with the ROM data for the pixel two clocks back.
    always_comb begin
        text_on = in_box_d2_r && visible_s && ({1'b0, col_d2_r} < reveal_cnt_r) &&
                  rom_data[3'd7 - bit_d2_r];
    end

    assign busy = busy_r;

endmodule

// File: tb/tb_draw_text_banner.sv
// Self-checking bench for draw_text_banner: a behavioural font ROM, a
// reference model of reveal/blink timing and geometry, and a scoreboard queue
// of expected pixel results compared when the DUT produces them.
module tb_draw_text_banner;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        frame_tick;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [6:0]  wr_char;
    logic [10:0] rom_addr, rom_addr0;
    logic [7:0]  rom_data, rom_data0;
    logic        text_on, text_on0;
    logic        busy, busy0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    draw_text_banner u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_tick(frame_tick),
        .pix_x(pix_x), .pix_y(pix_y), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .rom_addr(rom_addr), .rom_data(rom_data),
        .text_on(text_on), .busy(busy)
    );

    draw_text_banner #(.REVEAL_FRAMES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_tick(frame_tick),
        .pix_x(pix_x), .pix_y(pix_y), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .rom_addr(rom_addr0), .rom_data(rom_data0),
        .text_on(text_on0), .busy(busy0)
    );

    // Synthetic font: an arbitrary but deterministic pattern per (char,row).
    function automatic logic [7:0] font(input logic [10:0] a);
        logic [7:0] c;
        logic [7:0] r;
        c = {1'b0, a[10:4]};
        r = {4'b0, a[3:0]};
        return (c * 8'd37) ^ (r * 8'd91) ^ 8'hA5;
    endfunction

    // Font ROMs with one clock of read latency.
    always @(posedge clk) begin
        rom_data  <= font(rom_addr);
        rom_data0 <= font(rom_addr0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model of the default-parameter DUT
    logic [6:0] msg_m [16];
    int ticks_m = 0;

    function automatic int rc_m();
        return (ticks_m / 4 > 16) ? 16 : ticks_m / 4;
    endfunction

    function automatic bit vis_m();
        if (ticks_m < 64) return 1'b1;
        return (((ticks_m - 64) >> 5) % 2) == 0;
    endfunction

    function automatic bit in_box_m(input int x, input int y);
        return x >= 160 && x < 160 + 512 && y >= 192 && y < 192 + 64;
    endfunction

    typedef struct {
        logic        on;
        logic [10:0] addr;
        bit          chk_addr;
    } exp_t;

    exp_t q[$];

    task automatic step_pix(input int x, input int y, input bit do_wr = 1'b0,
                            input int wa = 0, input logic [6:0] wc = 7'd0);
        exp_t e;
        int col, grow, bitn;
        logic [7:0] f;
        @(negedge clk);
        if (q.size() > 0 && q[$].chk_addr) chk("rom_addr", 32'(rom_addr), 32'(q[$].addr));
        if (q.size() == 2) begin
            e = q.pop_front();
            chk("text_on", 32'(text_on), 32'(e.on));
        end
        pix_x   = 10'(x);
        pix_y   = 10'(y);
        wr_en   = do_wr;
        wr_addr = 5'(wa);
        wr_char = wc;
        e.on = 1'b0;
        e.addr = 11'd0;
        e.chk_addr = in_box_m(x, y);
        if (e.chk_addr) begin
            col  = (x - 160) >> 5;
            grow = ((y - 192) >> 2) & 15;
            bitn = ((x - 160) >> 2) & 7;
            e.addr = {msg_m[col], 4'(grow)};
            f = font(e.addr);
            e.on = vis_m() && (col < rc_m()) && f[7 - bitn];
        end
        q.push_back(e);
        if (do_wr && wa < 16) msg_m[wa] = wc;
    endtask

    task automatic flush();
        exp_t e;
        @(negedge clk);
        wr_en = 1'b0;
        if (q.size() > 0 && q[$].chk_addr) chk("rom_addr", 32'(rom_addr), 32'(q[$].addr));
        if (q.size() == 2) begin
            e = q.pop_front();
            chk("text_on", 32'(text_on), 32'(e.on));
        end
        @(negedge clk);
        while (q.size() > 0) begin
            e = q.pop_front();
            chk("text_on", 32'(text_on), 32'(e.on));
        end
    endtask

    task automatic raster(input int y, input int xa, input int xb);
        for (int x = xa; x <= xb; x++) step_pix(x, y);
        flush();
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            if (enable) ticks_m++;
        end
    endtask

    initial begin
        string m;
        byte b;
        logic [7:0] f;
        m = "GAME OVER       ";
        rst_n = 1'b0; enable = 1'b0; frame_tick = 1'b0; wr_en = 1'b0;
        pix_x = 10'd0; pix_y = 10'd0; wr_addr = 5'd0; wr_char = 7'd0;
        repeat (3) @(negedge clk);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_text_on", 32'(text_on), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rom_addr0", 32'(rom_addr0), 32'd0);
        chk("rst_text_on0", 32'(text_on0), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            b = m[i];
            wr_en = 1'b1; wr_addr = 5'(i); wr_char = b[6:0];
            msg_m[i] = b[6:0];
        end
        @(negedge clk);
        wr_en = 1'b0;

        // Arm both instances
        enable = 1'b1;
        tick(1);
        chk("t1_busy0", 32'(busy0), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);

        // Whole message at once: 'G' row 0 at the box corner
        @(negedge clk);
        pix_x = 10'd160; pix_y = 10'd192;
        @(negedge clk);
        chk("t1_addr0", 32'(rom_addr0), 32'h470);
        pix_x = 10'd172;
        @(negedge clk);
        f = font(11'h470);
        chk("t1_on0_bit0", 32'(text_on0), 32'(f[7]));
        chk("t1_on0_bit0_is1", 32'(text_on0), 32'd1);
        @(negedge clk);
        chk("t1_on0_bit3", 32'(text_on0), 32'(f[4]));

        // Typewriter: 10 ticks -> two characters shown
        tick(9);
        chk("t2_busy", 32'(busy), 32'd1);
        raster(200, 150, 320);

        // Fully revealed after 64 ticks, row 15 with both horizontal edges
        tick(54);
        chk("t2_hold_busy", 32'(busy), 32'd0);
        raster(255, 155, 680);
        raster(256, 158, 200);
        raster(191, 158, 200);

        // Blink: hidden for 32 frames, then shown again
        tick(32);
        raster(210, 160, 400);
        tick(32);
        raster(210, 160, 400);

        // Overwrite col 3 while it is being rastered; out-of-range write ignored
        for (int x = 256; x <= 290; x++) step_pix(x, 200, x == 270, 3, 7'h5A);
        flush();
        step_pix(0, 0, 1'b1, 31, 7'h51);
        step_pix(0, 0);
        flush();
        raster(200, 640, 675);

        // Enable falls during REVEAL together with a frame tick
        @(negedge clk);
        enable = 1'b0;
        ticks_m = 0;
        @(negedge clk);
        enable = 1'b1;
        tick(5);
        chk("t5_busy_rev", 32'(busy), 32'd1);
        @(negedge clk);
        enable = 1'b0;
        frame_tick = 1'b1;
        ticks_m = 0;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_busy0", 32'(busy0), 32'd0);
        raster(200, 160, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
